// File: rtl/scarv_soc_bram_arbiter_if.sv
// -----------------------------------------------------------------------------
// scarv_soc_bram_arbiter_if
//
// Purpose : One requester's connection to the shared BRAM arbiter. Each
//           requester (p0, p1) gets its own instance of this interface.
//
// Signals :
//   req       requester -> arbiter  access request, held with its payload until gnt
//   we[3:0]   requester -> arbiter  byte write strobes, 4'b0000 means read
//   addr      requester -> arbiter  byte address (LW bits, word aligned by BRAM)
//   wdata     requester -> arbiter  write data
//   lock      requester -> arbiter  keep ownership after this access
//   gnt       arbiter -> requester  combinational, access accepted this cycle
//   rsp_valid arbiter -> requester  registered, response to last cycle's grant
//   rdata     arbiter -> requester  read data, zero when rsp_valid is low
//
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface scarv_soc_bram_arbiter_if #(
    parameter int LW = 10
);
    logic          req;
    logic [3:0]    we;
    logic [LW-1:0] addr;
    logic [31:0]   wdata;
    logic          lock;
    logic          gnt;
    logic          rsp_valid;
    logic [31:0]   rdata;

    modport master (
        output req, we, addr, wdata, lock,
        input  gnt, rsp_valid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, lock,
        output gnt, rsp_valid, rdata
    );
endinterface

// File: rtl/scarv_soc_bram_arbiter.sv
// -----------------------------------------------------------------------------
// scarv_soc_bram_arbiter
//
// Purpose : Shares a single BRAM port between two requesters (p0, p1).
//           Round-robin arbitration, at most one access per cycle, fixed
//           1-cycle read latency with the response routed back to the
//           requester that was granted. Writes are acknowledged the same way
//           and return the word as it was before the write.
//
// Optional feature: define SCARV_SOC_BRAM_ARB_LOCK_EN to enable the lock
//           mechanism, letting one requester hold the port for atomic
//           read-modify-write sequences (bounded by LOCK_MAX grants). Without
//           the macro pN.lock is ignored and arbitration is pure round robin.
//
// Parameters:
//   DEPTH     BRAM depth in bytes; address width LW = $clog2(DEPTH)
//   LOCK_MAX  max consecutive locked grants before the lock is forced off
//
// Ports:
//   clka        clock, all logic on posedge
//   rsta        synchronous active-high reset
//   p0, p1      requester interfaces (slave modport)
//   bram_en     BRAM enable (any grant)
//   bram_we     BRAM byte write strobes of the winner
//   bram_addr   BRAM byte address of the winner
//   bram_din    BRAM write data of the winner
//   bram_dout   BRAM registered read data (1-cycle latency)
// -----------------------------------------------------------------------------
module scarv_soc_bram_arbiter #(
    parameter int DEPTH    = 1024,
    parameter int LOCK_MAX = 16,
    localparam int LW      = $clog2(DEPTH)
) (
    input  logic                    clka,
    input  logic                    rsta,
    scarv_soc_bram_arbiter_if.slave p0,
    scarv_soc_bram_arbiter_if.slave p1,
    output logic                    bram_en,
    output logic [3:0]              bram_we,
    output logic [LW-1:0]           bram_addr,
    output logic [31:0]             bram_din,
    input  logic [31:0]             bram_dout
);

    // Requester winning the next tie (0 = p0, 1 = p1).
    logic prio_q, prio_d;
    // A response is due this cycle, and which requester it belongs to.
    logic rsp_pend_q, rsp_pend_d;
    logic rsp_owner_q, rsp_owner_d;

    logic lock_act;
    logic lock_owner;
    logic elig0, elig1;
    logic gnt0, gnt1;
    logic any_gnt;
    logic rsp0, rsp1;

    // ---------------------------------------------------------------------
    // Lock state
    // ---------------------------------------------------------------------
`ifdef SCARV_SOC_BRAM_ARB_LOCK_EN
    logic       lock_act_q, lock_act_d;
    logic       lock_owner_q, lock_owner_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic [8:0] lock_cnt_inc;
    logic       owner_req;
    logic       win_lock;

    assign lock_act   = lock_act_q;
    assign lock_owner = lock_owner_q;

    always_comb begin
        lock_act_d   = lock_act_q;
        lock_owner_d = lock_owner_q;
        lock_cnt_d   = lock_cnt_q;
        lock_cnt_inc = {1'b0, lock_cnt_q} + 9'd1;
        owner_req    = lock_owner_q ? p1.req : p0.req;
        win_lock     = gnt1 ? p1.lock : p0.lock;

        // Owner went idle: it has given up the port.
        if (lock_act_q && !owner_req) begin
            lock_act_d = 1'b0;
            lock_cnt_d = 8'd0;
        end

        if (any_gnt) begin
            if (win_lock) begin
                if (lock_cnt_inc == 9'(LOCK_MAX)) begin
                    // Budget exhausted: release. prio already points at the
                    // other requester because the owner just won.
                    lock_act_d = 1'b0;
                    lock_cnt_d = 8'd0;
                end else begin
                    lock_act_d   = 1'b1;
                    lock_owner_d = gnt1;
                    lock_cnt_d   = lock_cnt_inc[7:0];
                end
            end else if (lock_act_q) begin
                // While locked only the owner can be granted, so this is the
                // owner finishing its atomic sequence.
                lock_act_d = 1'b0;
                lock_cnt_d = 8'd0;
            end
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            lock_act_q   <= 1'b0;
            lock_owner_q <= 1'b0;
            lock_cnt_q   <= 8'd0;
        end else begin
            lock_act_q   <= lock_act_d;
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end
`else
    logic unused_lock;

    assign lock_act    = 1'b0;
    assign lock_owner  = 1'b0;
    assign unused_lock = p0.lock ^ p1.lock ^ lock_owner;
`endif

    // ---------------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------------
    always_comb begin
        // With a lock active only the owner may compete.
        elig0   = p0.req & (~lock_act | ~lock_owner);
        elig1   = p1.req & (~lock_act |  lock_owner);
        gnt0    = ~rsta & elig0 & (~elig1 | ~prio_q);
        gnt1    = ~rsta & elig1 & (~elig0 |  prio_q);
        any_gnt = gnt0 | gnt1;
    end

    assign p0.gnt = gnt0;
    assign p1.gnt = gnt1;

    // ---------------------------------------------------------------------
    // BRAM drive: winner's payload, all zero when idle
    // ---------------------------------------------------------------------
    always_comb begin
        bram_en   = any_gnt;
        bram_we   = 4'b0000;
        bram_addr = '0;
        bram_din  = 32'd0;
        if (gnt0) begin
            bram_we   = p0.we;
            bram_addr = p0.addr;
            bram_din  = p0.wdata;
        end else if (gnt1) begin
            bram_we   = p1.we;
            bram_addr = p1.addr;
            bram_din  = p1.wdata;
        end
    end

    // ---------------------------------------------------------------------
    // Priority and response tracking
    // ---------------------------------------------------------------------
    always_comb begin
        prio_d      = prio_q;
        rsp_pend_d  = any_gnt;
        rsp_owner_d = gnt1;
        // Whoever wins hands the next tie to the other requester.
        if (any_gnt) begin
            prio_d = ~gnt1;
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            prio_q      <= 1'b0;
            rsp_pend_q  <= 1'b0;
            rsp_owner_q <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            rsp_pend_q  <= rsp_pend_d;
            rsp_owner_q <= rsp_owner_d;
        end
    end

    // The pending flag is still set during the first reset cycle, so the
    // outputs are also masked with rsta to drop that response.
    assign rsp0 = ~rsta & rsp_pend_q & ~rsp_owner_q;
    assign rsp1 = ~rsta & rsp_pend_q &  rsp_owner_q;

    assign p0.rsp_valid = rsp0;
    assign p1.rsp_valid = rsp1;
    assign p0.rdata     = rsp0 ? bram_dout : 32'd0;
    assign p1.rdata     = rsp1 ? bram_dout : 32'd0;

endmodule

// File: tb/tb_scarv_soc_bram_arbiter.sv
module tb_scarv_soc_bram_arbiter;

    localparam int LW = 10;

    logic        clka;
    logic        rsta;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [LW-1:0] bram_addr;
    logic [31:0] bram_din;
    logic [31:0] bram_dout;

    scarv_soc_bram_arbiter_if #(.LW(LW)) p0_if ();
    scarv_soc_bram_arbiter_if #(.LW(LW)) p1_if ();

    scarv_soc_bram_arbiter #(
        .DEPTH    (1024),
        .LOCK_MAX (4)
    ) dut (
        .clka      (clka),
        .rsta      (rsta),
        .p0        (p0_if),
        .p1        (p1_if),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_dout (bram_dout)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    // BRAM behavioural model: registered read-before-write, byte strobes.
    logic [31:0] mem [0:255];
    always @(posedge clka) begin
        if (bram_en) begin
            bram_dout <= mem[bram_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) mem[bram_addr[9:2]][8*b +: 8] <= bram_din[8*b +: 8];
        end
    end

    // Bench-side reference memory, updated from the stimulus it drives.
    logic [31:0] ref_mem [0:255];

    typedef struct packed {
        logic        owner;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic r, input logic [3:0] we,
                         input logic [LW-1:0] a, input logic [31:0] d, input logic l);
        if (p == 0) begin
            p0_if.req = r; p0_if.we = we; p0_if.addr = a; p0_if.wdata = d; p0_if.lock = l;
        end else begin
            p1_if.req = r; p1_if.we = we; p1_if.addr = a; p1_if.wdata = d; p1_if.lock = l;
        end
    endtask

    // One cycle: check the response due now against the scoreboard, check
    // the grant against the expected one, then record what the grant owes.
    task automatic step(input string tag, input logic eg0, input logic eg1);
        exp_t          e;
        logic          have;
        logic [3:0]    w_we;
        logic [LW-1:0] w_addr;
        logic [31:0]   w_din;
        @(negedge clka);
        have = (sb.size() > 0);
        e    = '0;
        if (have) e = sb.pop_front();
        if (rsta || !have) begin
            chk({tag, ".p0_rsp_valid"}, p0_if.rsp_valid, 0);
            chk({tag, ".p1_rsp_valid"}, p1_if.rsp_valid, 0);
            chk({tag, ".p0_rdata"},     p0_if.rdata, 0);
            chk({tag, ".p1_rdata"},     p1_if.rdata, 0);
        end else begin
            chk({tag, ".p0_rsp_valid"}, p0_if.rsp_valid, {31'd0, ~e.owner});
            chk({tag, ".p1_rsp_valid"}, p1_if.rsp_valid, {31'd0,  e.owner});
            chk({tag, ".p0_rdata"},     p0_if.rdata, e.owner ? 32'd0 : e.data);
            chk({tag, ".p1_rdata"},     p1_if.rdata, e.owner ? e.data : 32'd0);
        end
        chk({tag, ".p0_gnt"},  p0_if.gnt, {31'd0, eg0});
        chk({tag, ".p1_gnt"},  p1_if.gnt, {31'd0, eg1});
        chk({tag, ".bram_en"}, bram_en,   {31'd0, eg0 | eg1});
        w_we = 4'd0; w_addr = '0; w_din = 32'd0;
        if (eg0) begin
            w_we = p0_if.we; w_addr = p0_if.addr; w_din = p0_if.wdata;
        end else if (eg1) begin
            w_we = p1_if.we; w_addr = p1_if.addr; w_din = p1_if.wdata;
        end
        chk({tag, ".bram_we"},   bram_we,   w_we);
        chk({tag, ".bram_addr"}, bram_addr, w_addr);
        chk({tag, ".bram_din"},  bram_din,  w_din);
        if (!rsta && (eg0 || eg1)) begin
            e.owner = eg1;
            e.data  = ref_mem[w_addr[9:2]];
            sb.push_back(e);
            for (int b = 0; b < 4; b++)
                if (w_we[b]) ref_mem[w_addr[9:2]][8*b +: 8] = w_din[8*b +: 8];
        end
        $display("step %s: gnt=%b%b rsp=%b%b bram_en=%b addr=%h", tag,
                 p1_if.gnt, p0_if.gnt, p1_if.rsp_valid, p0_if.rsp_valid, bram_en, bram_addr);
        @(posedge clka);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'h0101_0101 * i ^ 32'h5A5A_0000;
            ref_mem[i] = 32'h0101_0101 * i ^ 32'h5A5A_0000;
        end
        mem[32'h10 >> 2] = 32'hDEADBEEF; ref_mem[32'h10 >> 2] = 32'hDEADBEEF;
        mem[32'h20 >> 2] = 32'hAABBCCDD; ref_mem[32'h20 >> 2] = 32'hAABBCCDD;

        rsta = 1'b1;
        drive(0, 0, 4'd0, 10'h000, 32'd0, 0);
        drive(1, 0, 4'd0, 10'h000, 32'd0, 0);
        step("rst_idle", 0, 0);
        // Requests during reset must not be granted.
        drive(0, 1, 4'd0, 10'h010, 32'd0, 0);
        drive(1, 1, 4'd0, 10'h020, 32'd0, 0);
        step("rst_req", 0, 0);

        // Both requesting from reset release: strict alternation starting at p0.
        rsta = 1'b0;
        step("rr0", 1, 0);
        step("rr1", 0, 1);
        step("rr2", 1, 0);
        step("rr3", 0, 1);
        drive(0, 0, 4'd0, 10'h000, 32'd0, 0);
        drive(1, 0, 4'd0, 10'h000, 32'd0, 0);
        step("rr_flush", 0, 0);

        // Single p0 read of a preloaded word.
        drive(0, 1, 4'd0, 10'h010, 32'd0, 0);
        step("rd10", 1, 0);
        drive(0, 0, 4'd0, 10'h000, 32'd0, 0);
        step("rd10_rsp", 0, 0);

        // p1 partial write, then p0 reads back the merged word.
        drive(1, 1, 4'b0011, 10'h020, 32'h12345678, 0);
        step("wr20", 0, 1);
        drive(1, 0, 4'd0, 10'h000, 32'd0, 0);
        drive(0, 1, 4'd0, 10'h020, 32'd0, 0);
        step("rd20", 1, 0);
        drive(0, 0, 4'd0, 10'h000, 32'd0, 0);
        step("rd20_rsp", 0, 0);

        // Unaligned address is passed through; word 0x10 comes back.
        drive(0, 1, 4'd0, 10'h013, 32'd0, 0);
        step("rd13", 1, 0);
        drive(0, 0, 4'd0, 10'h000, 32'd0, 0);
        step("rd13_rsp", 0, 0);

        // p1 wins after its last grant left prio on p0? prio is p1 now.
        drive(0, 1, 4'd0, 10'h030, 32'd0, 0);
        drive(1, 1, 4'b1111, 10'h040, 32'hCAFEF00D, 0);
        step("tie_p1", 0, 1);
        drive(1, 0, 4'd0, 10'h000, 32'd0, 0);
        step("tie_p0", 1, 0);
        drive(0, 0, 4'd0, 10'h000, 32'd0, 0);
        step("tie_flush", 0, 0);

        // Reset right after a grant drops the pending response.
        drive(0, 1, 4'd0, 10'h010, 32'd0, 0);
        step("pre_rst", 1, 0);
        rsta = 1'b1;
        drive(1, 1, 4'd0, 10'h044, 32'd0, 0);
        step("rst_drop", 0, 0);
        step("rst_hold", 0, 0);
        rsta = 1'b0;
        step("post_rst0", 1, 0);
        step("post_rst1", 0, 1);
        drive(0, 0, 4'd0, 10'h000, 32'd0, 0);
        drive(1, 0, 4'd0, 10'h000, 32'd0, 0);
        step("post_rst_flush", 0, 0);

`ifdef SCARV_SOC_BRAM_ARB_LOCK_EN
        // p0 locks for two accesses and unlocks on the third.
        drive(0, 1, 4'd0, 10'h010, 32'd0, 1);
        drive(1, 1, 4'd0, 10'h020, 32'd0, 0);
        step("lk0", 1, 0);
        step("lk1", 1, 0);
        drive(0, 1, 4'd0, 10'h010, 32'd0, 0);
        step("lk2", 1, 0);
        step("lk3", 0, 1);
        // Lock held continuously: forced release after LOCK_MAX=4 grants.
        drive(0, 1, 4'd0, 10'h014, 32'd0, 1);
        step("lm0", 1, 0);
        step("lm1", 1, 0);
        step("lm2", 1, 0);
        step("lm3", 1, 0);
        step("lm4", 0, 1);
        step("lm5", 1, 0);
`else
        // Lock input has no effect: still alternating.
        drive(0, 1, 4'd0, 10'h010, 32'd0, 1);
        drive(1, 1, 4'd0, 10'h020, 32'd0, 0);
        step("nolk0", 1, 0);
        step("nolk1", 0, 1);
        step("nolk2", 1, 0);
        step("nolk3", 0, 1);
`endif
        drive(0, 0, 4'd0, 10'h000, 32'd0, 0);
        drive(1, 0, 4'd0, 10'h000, 32'd0, 0);
        step("final_flush", 0, 0);
        step("final_idle", 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
